univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 80 ++++++++
 tb/tb_univ_shift_reg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ============================================================================
// univ_shift_reg -- universal shift register (hold/shift/rotate/load) with serial-in counter
// Revision 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic                       rotate,
   input  logic [WIDTH-1:0]           d,
   input  logic                       sin,
   output logic [WIDTH-1:0]           q,
   output logic                       sout,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       full
);

   localparam int                CNT_W = $clog2(WIDTH+1);
   localparam logic [1:0]        c_mode_hold  = 2'b00;
   localparam logic [1:0]        c_mode_right = 2'b01;
   localparam logic [1:0]        c_mode_left  = 2'b10;
   localparam logic [1:0]        c_mode_load  = 2'b11;
   localparam logic [CNT_W-1:0]  c_last_cnt   = CNT_W'(WIDTH - 1);

   logic             w_b_right;
   logic             w_b_left;
   logic             w_count;
   logic [WIDTH-1:0] w_q_next;

   assign w_b_right = rotate ? q[0]       : sin;
   assign w_b_left  = rotate ? q[WIDTH-1] : sin;
   assign w_count   = en && !rotate && (mode == c_mode_right || mode == c_mode_left);

   // sout tracks the bit that leaves in the currently selected direction
   assign sout = (mode == c_mode_left) ? q[WIDTH-1] : q[0];

   always_comb begin
      w_q_next = q;
      if (en) begin
         case (mode)
            c_mode_hold:  w_q_next = q;
            c_mode_right: w_q_next = {w_b_right, q[WIDTH-1:1]};
            c_mode_left:  w_q_next = {q[WIDTH-2:0], w_b_left};
            c_mode_load:  w_q_next = d;
            default:      w_q_next = q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q    <= RESET_VAL;
         cnt  <= '0;
         full <= 1'b0;
      end else begin
         q    <= w_q_next;
         full <= 1'b0;
         if (en && mode == c_mode_load) begin
            cnt <= '0;
         end else if (w_count) begin
            // wrap before reaching WIDTH so cnt never shows WIDTH on the output
            if (cnt == c_last_cnt) begin
               cnt  <= '0;
               full <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// tb_univ_shift_reg -- directed self-checking bench for univ_shift_reg (WIDTH=8)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       rotate;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic [3:0] cnt;
   logic       full;

   int n_compared   = 0;
   int n_mismatched = 0;

   univ_shift_reg #(
      .WIDTH     (8),
      .RESET_VAL (8'h00)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .rotate (rotate),
      .d      (d),
      .sin    (sin),
      .q      (q),
      .sout   (sout),
      .cnt    (cnt),
      .full   (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] e_q;

   initial begin
      rst = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hA5; sin = 1'b0; rotate = 1'b0;
      step();
      check_val("rst_q",    q,    8'h00);
      check_val("rst_cnt",  cnt,  4'd0);
      check_val("rst_full", full, 1'b0);

      // load then hold via en=0
      rst = 1'b1; mode = 2'b11; d = 8'hA5;
      step();
      check_val("load_q", q, 8'hA5);
      en = 1'b0; mode = 2'b01; sin = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_val("hold_en0_q",    q,    8'hA5);
      check_val("hold_en0_cnt",  cnt,  4'd0);
      check_val("hold_en0_full", full, 1'b0);

      // shift in eight ones from the left end
      en = 1'b1; mode = 2'b11; d = 8'h00;
      step();
      mode = 2'b01; sin = 1'b1; rotate = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         e_q = 8'hFF << (8 - i);
         check_val($sformatf("shin_q%0d", i),    q,    e_q);
         check_val($sformatf("shin_cnt%0d", i),  cnt,  (i == 8) ? 4'd0 : 4'(i));
         check_val($sformatf("shin_full%0d", i), full, (i == 8) ? 1'b1 : 1'b0);
      end
      mode = 2'b00;
      step();
      check_val("after_wrap_full", full, 1'b0);
      check_val("after_wrap_q",    q,    8'hFF);
      check_val("after_wrap_cnt",  cnt,  4'd0);

      // rotate left
      mode = 2'b11; d = 8'h81;
      step();
      mode = 2'b10; rotate = 1'b1;
      step();
      check_val("rot_q",    q,    8'h03);
      check_val("rot_cnt",  cnt,  4'd0);
      check_val("rot_full", full, 1'b0);
      check_val("rot_sout", sout, 1'b0);

      // shift left with serial in
      mode = 2'b11; d = 8'hA5; rotate = 1'b0;
      step();
      mode = 2'b10; sin = 1'b0;
      #1;
      check_val("shl_sout_pre", sout, 1'b1);
      step();
      check_val("shl_q",   q,   8'h4A);
      check_val("shl_cnt", cnt, 4'd1);
      mode = 2'b01;
      #1;
      check_val("sout_mode01", sout, 1'b0);
      mode = 2'b00;
      step();
      check_val("hold_m00_q",   q,   8'h4A);
      check_val("hold_m00_cnt", cnt, 4'd1);

      // reset mid-shift discards partial count
      mode = 2'b11; d = 8'h00;
      step();
      mode = 2'b01; sin = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         check_val($sformatf("mid_full%0d", i), full, 1'b0);
      end
      check_val("mid_cnt5", cnt, 4'd5);
      rst = 1'b0;
      step();
      check_val("mid_rst_q",    q,    8'h00);
      check_val("mid_rst_cnt",  cnt,  4'd0);
      check_val("mid_rst_full", full, 1'b0);
      rst = 1'b1;
      step();
      check_val("post_rst_cnt",  cnt,  4'd1);
      check_val("post_rst_full", full, 1'b0);

      // mixed directions count together toward the wrap
      sin = 1'b1;
      for (int i = 0; i < 3; i++) step();
      mode = 2'b10; sin = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_val("mix_cnt7",  cnt,  4'd7);
      check_val("mix_full7", full, 1'b0);
      step();
      check_val("mix_wrap_cnt",  cnt,  4'd0);
      check_val("mix_wrap_full", full, 1'b1);
      step();
      check_val("mix_next_cnt",  cnt,  4'd1);
      check_val("mix_next_full", full, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire
